// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, instruction ROM request, skid buffer and F/D latch
// Optional FETCH_STATS_EN adds fetch/flush/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          IMEM_ADDR_BITS = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [31:0]               imem_data,
  output logic [31:0]               FD_pc,
  output logic [31:0]               FD_instruction,
  output logic                      FD_valid,
  output logic                      DX_kill
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]               stat_fetched,
  output logic [31:0]               stat_flushes,
  output logic [31:0]               stat_stall_cycles
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;

  logic        front_valid;
  logic [31:0] front_pc;
  logic [31:0] front_instr;

  // The skid buffer, when full, is older than whatever the ROM shows now.
  always_comb begin
    front_valid = skid_valid_q | req_valid_q;
    front_pc    = skid_valid_q ? skid_pc_q : req_pc_q;
    front_instr = skid_valid_q ? skid_instr_q : imem_data;
  end

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    fd_valid_d   = fd_valid_q;
    fd_pc_d      = fd_pc_q;
    fd_instr_d   = fd_instr_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      fd_valid_d   = 1'b0;
      fd_pc_d      = 32'h0;
      fd_instr_d   = 32'h0;
    end else if (stall) begin
      // Park the in-flight read; the repeated read of pc_q is discarded.
      if (!skid_valid_q && req_valid_q) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_instr_d = imem_data;
      end
      req_valid_d = 1'b0;
    end else begin
      fd_valid_d   = front_valid;
      fd_pc_d      = front_valid ? front_pc : 32'h0;
      fd_instr_d   = front_valid ? front_instr : 32'h0;
      skid_valid_d = 1'b0;
      req_pc_d     = pc_q;
      req_valid_d  = 1'b1;
      pc_d         = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      req_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      fd_valid_q   <= 1'b0;
      fd_pc_q      <= 32'h0;
      fd_instr_q   <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      fd_valid_q   <= fd_valid_d;
      fd_pc_q      <= fd_pc_d;
      fd_instr_q   <= fd_instr_d;
    end
  end

  assign imem_addr      = pc_q[IMEM_ADDR_BITS-1:0];
  assign FD_pc          = fd_pc_q;
  assign FD_instruction = fd_instr_q;
  assign FD_valid       = fd_valid_q;
  assign DX_kill        = redirect_valid;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_flushes_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched_q <= 32'h0;
      stat_flushes_q <= 32'h0;
      stat_stall_q   <= 32'h0;
    end else if (redirect_valid) begin
      stat_flushes_q <= stat_flushes_q + 32'd1;
    end else if (stall) begin
      stat_stall_q <= stat_stall_q + 32'd1;
    end else if (front_valid) begin
      stat_fetched_q <= stat_fetched_q + 32'd1;
    end
  end

  assign stat_fetched      = stat_fetched_q;
  assign stat_flushes      = stat_flushes_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
